// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main sequencer of the 16-bit multi-cycle CPU, driving per-state datapath strobes.
module multicycle_control_fsm (
  input  logic       CLK,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [1:0] br_sel,
  output logic       PCWrite,
  output logic       PC_isbranch,
  output logic [1:0] branchType,
  output logic       PCSource,
  output logic       IR_write,
  output logic       IorD,
  output logic       mem_write,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       halted,
  output logic       bad_op
);
  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_SUB  = 7'h02;
  localparam logic [6:0] OP_ADDI = 7'h03;
  localparam logic [6:0] OP_LW   = 7'h10;
  localparam logic [6:0] OP_SW   = 7'h11;
  localparam logic [6:0] OP_BR   = 7'h20;
  localparam logic [6:0] OP_JMP  = 7'h30;
  localparam logic [6:0] OP_HALT = 7'h7F;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_FETCH2 = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4, S_WB_ALU = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7,
    S_MEM_RD2 = 4'd8, S_WB_MEM = 4'd9, S_MEM_WR = 4'd10, S_BRANCH = 4'd11,
    S_JUMP = 4'd12, S_HALT = 4'd13
  } state_t;
  state_t r_state, w_next;
  logic   r_bad_op, w_set_bad;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_state  <= S_FETCH;
      r_bad_op <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_bad_op <= r_bad_op | w_set_bad;
    end
  // Unlisted strobes default to 0, so the reset/FETCH state never writes anything.
  always_comb begin
    w_next      = S_FETCH;
    w_set_bad   = 1'b0;
    PCWrite     = 1'b0;
    PC_isbranch = 1'b0;
    branchType  = 2'd0;
    PCSource    = 1'b0;
    IR_write    = 1'b0;
    IorD        = 1'b0;
    mem_write   = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_FETCH2;
      S_FETCH2: begin
        IR_write = 1'b1;
        ALUSrcB  = 2'd1;
        PCWrite  = 1'b1;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'd2;
        case (opcode)
          OP_ADD, OP_SUB: w_next = S_EXEC_R;
          OP_ADDI:        w_next = S_EXEC_I;
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_BR:          w_next = S_BRANCH;
          OP_JMP:         w_next = S_JUMP;
          OP_HALT:        w_next = S_HALT;
          default:        w_set_bad = 1'b1;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = (opcode == OP_SUB) ? 2'd1 : 2'd0;
        w_next  = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        w_next  = S_WB_ALU;
      end
      S_WB_ALU: RegWrite = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'd2;
        w_next    = (opcode == OP_SW) ? S_MEM_WR : (opcode == OP_LW) ? S_MEM_RD : S_FETCH;
        w_set_bad = (opcode != OP_SW) && (opcode != OP_LW);
      end
      S_MEM_RD: begin
        IorD   = 1'b1;
        w_next = S_MEM_RD2;
      end
      S_MEM_RD2: begin
        IorD   = 1'b1;
        w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'd1;
        PC_isbranch = 1'b1;
        branchType  = br_sel;
        PCSource    = 1'b1;
      end
      S_JUMP: begin
        ALUSrcB  = 2'd2;
        ALUOp    = 2'd2;
        PCSource = 1'b1;
        PCWrite  = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_set_bad = 1'b1;
    endcase
  end
  assign state  = r_state;
  assign bad_op = r_bad_op;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction streams checked against a per-instruction state-trace model.
module tb_multicycle_control_fsm;
  logic       CLK, reset;
  logic [6:0] opcode;
  logic [1:0] br_sel;
  logic       PCWrite, PC_isbranch, PCSource, IR_write, IorD, mem_write;
  logic       RegWrite, MemtoReg, ALUSrcA, halted, bad_op;
  logic [1:0] branchType, ALUSrcB, ALUOp;
  logic [3:0] state;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       m_bad;
  logic [6:0] op_tab [8] = '{7'h01, 7'h02, 7'h03, 7'h10, 7'h11, 7'h20, 7'h30, 7'h7F};
  multicycle_control_fsm dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .br_sel(br_sel),
    .PCWrite(PCWrite), .PC_isbranch(PC_isbranch), .branchType(branchType),
    .PCSource(PCSource), .IR_write(IR_write), .IorD(IorD), .mem_write(mem_write),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .halted(halted), .bad_op(bad_op)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // Expected state trace of one instruction, straight from the per-opcode cycle lists.
  function automatic void trace(input logic [6:0] op, output int q[$]);
    q = '{0, 1, 2};
    case (op)
      7'h01, 7'h02: q = {q, 3, 5};
      7'h03:        q = {q, 4, 5};
      7'h10:        q = {q, 6, 7, 8, 9};
      7'h11:        q = {q, 6, 10};
      7'h20:        q.push_back(11);
      7'h30:        q.push_back(12);
      7'h7F:        repeat (20) q.push_back(13);
      default:      ;
    endcase
  endfunction
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'h01, 7'h02, 7'h03, 7'h10, 7'h11, 7'h20, 7'h30, 7'h7F};
  endfunction
  // {PCWrite,PC_isbranch,branchType,PCSource,IR_write,IorD,mem_write,RegWrite,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,halted}
  function automatic logic [15:0] exp_ctl(input int st, input logic [6:0] op, input logic [1:0] bs);
    logic [1:0] asb, aop;
    asb = (st == 1) ? 2'd1 : (st inside {2, 4, 6, 12}) ? 2'd2 : 2'd0;
    aop = (st == 12) ? 2'd2 : (st == 11 || (st == 3 && op == 7'h02)) ? 2'd1 : 2'd0;
    return {st == 1 || st == 12, st == 11, (st == 11) ? bs : 2'd0, st == 11 || st == 12,
            st == 1, st inside {7, 8, 10}, st == 10, st == 5 || st == 9, st == 9,
            st inside {3, 4, 6, 11}, asb, aop, st == 13};
  endfunction
  function automatic logic [15:0] got_ctl();
    return {PCWrite, PC_isbranch, branchType, PCSource, IR_write, IorD, mem_write,
            RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, halted};
  endfunction
  task automatic check_cycle(input int st, input logic [6:0] op, input logic [1:0] bs);
    chk("state", state, st);
    chk("ctl", got_ctl(), exp_ctl(st, op, bs));
    chk("bad_op", bad_op, m_bad);
    chk("one_write", $onehot0({IR_write, RegWrite, mem_write}), 1);
    chk("pc_excl", PCWrite & PC_isbranch, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_bad = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_ctl", got_ctl(), 16'h0);
    chk("rst_bad", bad_op, 0);
    @(negedge CLK);
    reset = 1'b0;
  endtask
  // Called at a negedge with the machine in FETCH; returns at the next instruction's FETCH negedge.
  task automatic run_instr(input logic [6:0] op, input logic [1:0] bs);
    int q[$];
    opcode = op;
    br_sel = bs;
    trace(op, q);
    foreach (q[i]) begin
      check_cycle(q[i], op, bs);
      if (q[i] == 2 && !is_legal(op)) m_bad = 1'b1;
      @(negedge CLK);
    end
    if (op == 7'h7F) begin
      chk("halt_hold", state, 13);
      do_reset();
    end
  endtask
  initial begin
    reset = 1'b1;
    opcode = 7'h00;
    br_sel = 2'd0;
    m_bad = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_state", state, 0);
    chk("rst_ctl", got_ctl(), 16'h0);
    chk("rst_bad", bad_op, 0);
    reset = 1'b0;
    run_instr(7'h01, 2'd0);
    run_instr(7'h10, 2'd1);
    run_instr(7'h11, 2'd3);
    run_instr(7'h20, 2'b10);
    run_instr(7'h55, 2'd0);
    run_instr(7'h02, 2'd0);
    run_instr(7'h03, 2'd0);
    run_instr(7'h30, 2'd0);
    chk("bad_sticky", bad_op, 1);
    run_instr(7'h7F, 2'd0);
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 9) < 8) ? op_tab[$urandom_range(0, 6)] : 7'($urandom);
      if ($urandom_range(0, 15) == 0) op = 7'h7F;
      run_instr(op, 2'($urandom));
    end
    // Asynchronous reset landing in the middle of a store must kill mem_write before the next edge.
    opcode = 7'h11;
    br_sel = 2'd0;
    for (int s = 0; s < 4; s++) @(negedge CLK);
    chk("mw_state", state, 10);
    chk("mw_write", mem_write, 1);
    #2 reset = 1'b1;
    #1;
    m_bad = 1'b0;
    chk("async_state", state, 0);
    chk("async_mw", mem_write, 0);
    @(negedge CLK);
    reset = 1'b0;
    run_instr(7'h10, 2'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
